// File: rtl/chanlink_frame_packer.sv
// chanlink_frame_packer: drains the FIFO-ring read stream (dout/dvalid/last_wrd) into link frames
// of SOF, data words, optional CRC and EOF, with K-char idle fill between and inside frames.
// Optional feature macro: CHANLINK_FRAME_CRC_EN adds a CRC-16-CCITT word ahead of EOF.
// All outputs are registered; state_q names the content currently presented on txd.
module chanlink_frame_packer #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned MAX_WORDS  = 1024
) (
  input  logic        rclk,
  input  logic        rst,
  input  logic        dvalid,
  input  logic [15:0] dout,
  input  logic        last_wrd,
  output logic [15:0] txd,
  output logic [1:0]  txk,
  output logic        frm_active,
  output logic [11:0] wrd_cnt,
  output logic        ovfl,
  output logic        trunc
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned OccW = PtrW + 1;
  localparam logic [15:0] IdleCode = 16'h50BC;
  localparam logic [15:0] SofCode  = 16'h55FB;
  localparam logic [15:0] EofCode  = 16'h55FD;
  localparam logic [15:0] MaxWords = 16'(MAX_WORDS);
  localparam logic [OccW-1:0] OccFull = OccW'(FIFO_DEPTH);
  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);

  typedef enum logic [2:0] {
    StIdle,
    StSof,
    StData,
`ifdef CHANLINK_FRAME_CRC_EN
    StCrc,
`endif
    StEof,
    StGap
  } state_e;

  // Elastic buffer: {last, data}
  logic [16:0]     mem [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [OccW-1:0] occ_q;
  logic            empty, full, push, pop, drop;
  logic            fsm_pop, disc_pop;
  logic [16:0]     rd_word;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        done_q, done_d;   // frame body finished (last seen or truncated)
  logic        disc_q, disc_d;   // discarding the tail of a truncated event
  logic [15:0] txd_q, txd_d;
  logic [1:0]  txk_q, txk_d;
  logic        frm_q, frm_d;
  logic [11:0] wrd_q, wrd_d;
  logic        ovfl_q, trunc_q, trunc_d;
`ifdef CHANLINK_FRAME_CRC_EN
  logic [15:0] crc_q, crc_d;

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [15:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 15; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction
`endif

  assign empty   = (occ_q == '0);
  assign full    = (occ_q == OccFull);
  assign pop     = fsm_pop | disc_pop;
  // A full buffer that is popped this cycle still accepts the new word
  assign push    = dvalid & (~full | pop);
  assign drop    = dvalid & full & ~pop;
  assign rd_word = mem[rd_ptr_q];

  // Buffer storage; a dropped last word moves its flag onto the newest stored word
  always_ff @(posedge rclk) begin
    if (!rst) begin
      if (push)                  mem[wr_ptr_q] <= {last_wrd, dout};
      else if (drop && last_wrd) mem[wr_ptr_q - PtrOne][16] <= 1'b1;
    end
  end

  // Buffer pointers, occupancy and sticky overflow flag
  always_ff @(posedge rclk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      ovfl_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
      if (push && !pop)      occ_q <= occ_q + OccW'(1);
      else if (!push && pop) occ_q <= occ_q - OccW'(1);
      if (drop) ovfl_q <= 1'b1;
    end
  end

  // Next state, next output word and buffer pops
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = done_q;
    disc_d   = disc_q;
    trunc_d  = trunc_q;
    wrd_d    = wrd_q;
    txd_d    = IdleCode;
    txk_d    = 2'b01;
    fsm_pop  = 1'b0;
    disc_pop = 1'b0;
`ifdef CHANLINK_FRAME_CRC_EN
    crc_d    = crc_q;
`endif
    if (disc_q && !empty) begin
      disc_pop = 1'b1;
      if (rd_word[16]) disc_d = 1'b0;
    end
    unique case (state_q)
      StIdle, StGap: begin
        if (!empty && !disc_q) begin
          state_d = StSof;
          txd_d   = SofCode;
          cnt_d   = '0;
          done_d  = 1'b0;
`ifdef CHANLINK_FRAME_CRC_EN
          crc_d   = 16'hFFFF;
`endif
        end else begin
          state_d = StIdle;
        end
      end
      StSof, StData: begin
        if (done_q) begin
`ifdef CHANLINK_FRAME_CRC_EN
          state_d = StCrc;
          txd_d   = crc_q;
          txk_d   = 2'b00;
`else
          state_d = StEof;
          txd_d   = EofCode;
          wrd_d   = (cnt_q > 16'h0FFF) ? 12'hFFF : cnt_q[11:0];
`endif
        end else begin
          state_d = StData;
          if (!empty) begin
            fsm_pop = 1'b1;
            txd_d   = rd_word[15:0];
            txk_d   = 2'b00;
            cnt_d   = cnt_q + 16'd1;
`ifdef CHANLINK_FRAME_CRC_EN
            crc_d   = crc16_step(crc_q, rd_word[15:0]);
`endif
            if (rd_word[16]) begin
              done_d = 1'b1;
            end else if (cnt_d == MaxWords) begin
              done_d  = 1'b1;
              trunc_d = 1'b1;
              disc_d  = 1'b1;
            end
          end
        end
      end
`ifdef CHANLINK_FRAME_CRC_EN
      StCrc: begin
        state_d = StEof;
        txd_d   = EofCode;
        wrd_d   = (cnt_q > 16'h0FFF) ? 12'hFFF : cnt_q[11:0];
      end
`endif
      StEof: state_d = StGap;
      default: state_d = StIdle;
    endcase
    frm_d = !(state_d == StIdle || state_d == StGap);
  end

  // FSM and registered link outputs
  always_ff @(posedge rclk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      disc_q  <= 1'b0;
      trunc_q <= 1'b0;
      wrd_q   <= '0;
      txd_q   <= IdleCode;
      txk_q   <= 2'b01;
      frm_q   <= 1'b0;
`ifdef CHANLINK_FRAME_CRC_EN
      crc_q   <= 16'hFFFF;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      disc_q  <= disc_d;
      trunc_q <= trunc_d;
      wrd_q   <= wrd_d;
      txd_q   <= txd_d;
      txk_q   <= txk_d;
      frm_q   <= frm_d;
`ifdef CHANLINK_FRAME_CRC_EN
      crc_q   <= crc_d;
`endif
    end
  end

  assign txd        = txd_q;
  assign txk        = txk_q;
  assign frm_active = frm_q;
  assign wrd_cnt    = wrd_q;
  assign ovfl       = ovfl_q;
  assign trunc      = trunc_q;

endmodule

// File: tb/tb_chanlink_frame_packer.sv
// Directed bench for chanlink_frame_packer: three instances (default, FIFO_DEPTH=4, MAX_WORDS=8)
// share one stimulus stream; each test resets, drives a vector list and checks the selected one.
module tb_chanlink_frame_packer;

  localparam logic [15:0] IDLE = 16'h50BC;
  localparam logic [15:0] SOF  = 16'h55FB;
  localparam logic [15:0] EOF  = 16'h55FD;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        dvalid = 1'b0;
  logic [15:0] dout = 16'h0;
  logic        last_wrd = 1'b0;

  logic [15:0] d_txd, s_txd, t_txd, m_txd;
  logic [1:0]  d_txk, s_txk, t_txk, m_txk;
  logic        d_frm, s_frm, t_frm, m_frm;
  logic [11:0] d_cnt, s_cnt, t_cnt, m_cnt;
  logic        d_ovf, s_ovf, t_ovf, m_ovf;
  logic        d_trn, s_trn, t_trn, m_trn;

  chanlink_frame_packer #(.FIFO_DEPTH(8), .MAX_WORDS(1024)) u_dut (
    .rclk(clk), .rst(rst), .dvalid(dvalid), .dout(dout), .last_wrd(last_wrd),
    .txd(d_txd), .txk(d_txk), .frm_active(d_frm), .wrd_cnt(d_cnt), .ovfl(d_ovf), .trunc(d_trn)
  );
  chanlink_frame_packer #(.FIFO_DEPTH(4), .MAX_WORDS(1024)) u_small (
    .rclk(clk), .rst(rst), .dvalid(dvalid), .dout(dout), .last_wrd(last_wrd),
    .txd(s_txd), .txk(s_txk), .frm_active(s_frm), .wrd_cnt(s_cnt), .ovfl(s_ovf), .trunc(s_trn)
  );
  chanlink_frame_packer #(.FIFO_DEPTH(8), .MAX_WORDS(8)) u_trunc (
    .rclk(clk), .rst(rst), .dvalid(dvalid), .dout(dout), .last_wrd(last_wrd),
    .txd(t_txd), .txk(t_txk), .frm_active(t_frm), .wrd_cnt(t_cnt), .ovfl(t_ovf), .trunc(t_trn)
  );

  int sel = 0;
  always_comb begin
    case (sel)
      1: begin
        m_txd = s_txd; m_txk = s_txk; m_frm = s_frm; m_cnt = s_cnt; m_ovf = s_ovf; m_trn = s_trn;
      end
      2: begin
        m_txd = t_txd; m_txk = t_txk; m_frm = t_frm; m_cnt = t_cnt; m_ovf = t_ovf; m_trn = t_trn;
      end
      default: begin
        m_txd = d_txd; m_txk = d_txk; m_frm = d_frm; m_cnt = d_cnt; m_ovf = d_ovf; m_trn = d_trn;
      end
    endcase
  end

  int n_cmp = 0;
  int n_fail = 0;

  logic        st_v[$], st_l[$], st_r[$];
  logic [15:0] st_d[$];
  logic [15:0] obs_d[$], exp_d[$];
  logic [1:0]  obs_k[$], exp_k[$];
  logic        obs_f[$], exp_f[$];
  logic [11:0] obs_c[$];
  logic        obs_o[$], obs_t[$];

  // Bit-serial CRC-16-CCITT reference, MSB first
  function automatic logic [15:0] crc_ref(input logic [15:0] crc, input logic [15:0] word);
    logic [15:0] c, w;
    logic        fb;
    c = crc;
    w = word;
    for (int b = 0; b < 16; b++) begin
      fb = c[15] ^ w[15];
      c  = c << 1;
      if (fb) c = c ^ 16'h1021;
      w  = w << 1;
    end
    return c;
  endfunction

  task automatic clear_q();
    st_v.delete(); st_d.delete(); st_l.delete(); st_r.delete();
    obs_d.delete(); obs_k.delete(); obs_f.delete(); obs_c.delete(); obs_o.delete(); obs_t.delete();
    exp_d.delete(); exp_k.delete(); exp_f.delete();
  endtask

  task automatic stim(input logic v, input logic [15:0] d, input logic l, input logic r);
    st_v.push_back(v); st_d.push_back(d); st_l.push_back(l); st_r.push_back(r);
  endtask

  task automatic e_idle();
    exp_d.push_back(IDLE); exp_k.push_back(2'b01); exp_f.push_back(1'b0);
  endtask
  task automatic e_sof();
    exp_d.push_back(SOF); exp_k.push_back(2'b01); exp_f.push_back(1'b1);
  endtask
  task automatic e_eof();
    exp_d.push_back(EOF); exp_k.push_back(2'b01); exp_f.push_back(1'b1);
  endtask
  task automatic e_word(input logic [15:0] w);
    exp_d.push_back(w); exp_k.push_back(2'b00); exp_f.push_back(1'b1);
  endtask

  // Drive one vector per cycle (zeros past the list) and record outputs #1 after each edge
  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      if (i < st_v.size()) begin
        dvalid = st_v[i]; dout = st_d[i]; last_wrd = st_l[i]; rst = st_r[i];
      end else begin
        dvalid = 1'b0; dout = 16'h0; last_wrd = 1'b0; rst = 1'b0;
      end
      @(posedge clk);
      #1;
      obs_d.push_back(m_txd); obs_k.push_back(m_txk); obs_f.push_back(m_frm);
      obs_c.push_back(m_cnt); obs_o.push_back(m_ovf); obs_t.push_back(m_trn);
    end
    dvalid = 1'b0; dout = 16'h0; last_wrd = 1'b0; rst = 1'b0;
  endtask

  task automatic do_reset();
    clear_q();
    stim(1'b0, 16'h0, 1'b0, 1'b1);
    stim(1'b0, 16'h0, 1'b0, 1'b1);
    run_cycles(2);
    clear_q();
  endtask

  task automatic test_reset();
    sel = 0;
    clear_q();
    for (int i = 0; i < 5; i++) stim(1'b0, 16'h0, 1'b0, 1'b1);
    run_cycles(5);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (obs_d[i] !== IDLE || obs_k[i] !== 2'b01 || obs_f[i] !== 1'b0 || obs_c[i] !== 12'h0 ||
          obs_o[i] !== 1'b0 || obs_t[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset cycle %0d: got txd=%h txk=%b frm=%b cnt=%h ovfl=%b trunc=%b, want 50bc 01 0 000 0 0",
                 i, obs_d[i], obs_k[i], obs_f[i], obs_c[i], obs_o[i], obs_t[i]);
      end
    end
  endtask

  task automatic test_four_words();
    logic [15:0] crc;
    int          eof_i;
    sel = 0;
    do_reset();
    for (int i = 1; i <= 4; i++) stim(1'b1, 16'(i), (i == 4), 1'b0);
    crc = 16'hFFFF;
    for (int i = 1; i <= 4; i++) crc = crc_ref(crc, 16'(i));
    e_idle(); e_sof();
    for (int i = 1; i <= 4; i++) e_word(16'(i));
`ifdef CHANLINK_FRAME_CRC_EN
    e_word(crc);
    eof_i = 7;
`else
    eof_i = 6;
`endif
    e_eof(); e_idle(); e_idle();
    run_cycles(exp_d.size());
    for (int i = 0; i < exp_d.size(); i++) begin
      n_cmp++;
      if (obs_d[i] !== exp_d[i] || obs_k[i] !== exp_k[i] || obs_f[i] !== exp_f[i]) begin
        n_fail++;
        $display("FAIL four_words cycle %0d: got txd=%h txk=%b frm=%b, want txd=%h txk=%b frm=%b",
                 i, obs_d[i], obs_k[i], obs_f[i], exp_d[i], exp_k[i], exp_f[i]);
      end
    end
    n_cmp++;
    if (obs_c[eof_i - 1] !== 12'd0 || obs_c[eof_i] !== 12'd4) begin
      n_fail++;
      $display("FAIL four_words wrd_cnt: got %0d then %0d, want 0 then 4",
               obs_c[eof_i - 1], obs_c[eof_i]);
    end
  endtask

  task automatic test_single_zero();
    sel = 0;
    do_reset();
    stim(1'b1, 16'h0000, 1'b1, 1'b0);
    e_idle(); e_sof(); e_word(16'h0000);
`ifdef CHANLINK_FRAME_CRC_EN
    e_word(crc_ref(16'hFFFF, 16'h0000));
`endif
    e_eof(); e_idle();
    run_cycles(exp_d.size());
    for (int i = 0; i < exp_d.size(); i++) begin
      n_cmp++;
      if (obs_d[i] !== exp_d[i] || obs_k[i] !== exp_k[i] || obs_f[i] !== exp_f[i]) begin
        n_fail++;
        $display("FAIL single_zero cycle %0d: got txd=%h txk=%b frm=%b, want txd=%h txk=%b frm=%b",
                 i, obs_d[i], obs_k[i], obs_f[i], exp_d[i], exp_k[i], exp_f[i]);
      end
    end
    n_cmp++;
    if (obs_c[exp_d.size() - 1] !== 12'd1) begin
      n_fail++;
      $display("FAIL single_zero wrd_cnt: got %0d, want 1", obs_c[exp_d.size() - 1]);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a[3];
    logic [15:0] b[3];
    logic [15:0] ca, cb;
    sel = 0;
    do_reset();
    a[0] = 16'h1111; a[1] = 16'h2222; a[2] = 16'h3333;
    b[0] = 16'hA5A5; b[1] = 16'h5A5A; b[2] = 16'hFFFF;
    ca = 16'hFFFF;
    cb = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      stim(1'b1, a[i], (i == 2), 1'b0);
      ca = crc_ref(ca, a[i]);
    end
    for (int i = 0; i < 3; i++) begin
      stim(1'b1, b[i], (i == 2), 1'b0);
      cb = crc_ref(cb, b[i]);
    end
    e_idle(); e_sof();
    for (int i = 0; i < 3; i++) e_word(a[i]);
`ifdef CHANLINK_FRAME_CRC_EN
    e_word(ca);
`endif
    e_eof(); e_idle(); e_sof();
    for (int i = 0; i < 3; i++) e_word(b[i]);
`ifdef CHANLINK_FRAME_CRC_EN
    e_word(cb);
`endif
    e_eof(); e_idle();
    run_cycles(exp_d.size());
    for (int i = 0; i < exp_d.size(); i++) begin
      n_cmp++;
      if (obs_d[i] !== exp_d[i] || obs_k[i] !== exp_k[i] || obs_f[i] !== exp_f[i]) begin
        n_fail++;
        $display("FAIL back_to_back cycle %0d: got txd=%h txk=%b frm=%b, want txd=%h txk=%b frm=%b",
                 i, obs_d[i], obs_k[i], obs_f[i], exp_d[i], exp_k[i], exp_f[i]);
      end
    end
    n_cmp++;
    if (obs_c[exp_d.size() - 1] !== 12'd3 || obs_o[exp_d.size() - 1] !== 1'b0) begin
      n_fail++;
      $display("FAIL back_to_back end: got wrd_cnt=%0d ovfl=%b, want 3 0",
               obs_c[exp_d.size() - 1], obs_o[exp_d.size() - 1]);
    end
  endtask

  // One-word event ahead of a 12-word burst: the frame overhead backs the depth-4 buffer up
  task automatic test_overflow();
    logic [15:0] c0, c1;
    logic [11:0] want_cnt;
    int          last_i;
    sel = 1;
    do_reset();
    stim(1'b1, 16'h00A0, 1'b1, 1'b0);
    for (int i = 1; i <= 12; i++) stim(1'b1, 16'h0100 + 16'(i), (i == 12), 1'b0);
    c0 = crc_ref(16'hFFFF, 16'h00A0);
    c1 = 16'hFFFF;
    e_idle(); e_sof(); e_word(16'h00A0);
`ifdef CHANLINK_FRAME_CRC_EN
    e_word(c0);
`endif
    e_eof(); e_idle(); e_sof();
    for (int i = 1; i <= 12; i++) begin
`ifdef CHANLINK_FRAME_CRC_EN
      if (i == 5 || i == 6) continue;
`else
      if (i == 5) continue;
`endif
      e_word(16'h0100 + 16'(i));
      c1 = crc_ref(c1, 16'h0100 + 16'(i));
    end
`ifdef CHANLINK_FRAME_CRC_EN
    e_word(c1);
    want_cnt = 12'd10;
`else
    want_cnt = 12'd11;
`endif
    e_eof(); e_idle();
    run_cycles(exp_d.size());
    for (int i = 0; i < exp_d.size(); i++) begin
      n_cmp++;
      if (obs_d[i] !== exp_d[i] || obs_k[i] !== exp_k[i] || obs_f[i] !== exp_f[i]) begin
        n_fail++;
        $display("FAIL overflow cycle %0d: got txd=%h txk=%b frm=%b, want txd=%h txk=%b frm=%b",
                 i, obs_d[i], obs_k[i], obs_f[i], exp_d[i], exp_k[i], exp_f[i]);
      end
    end
    last_i = exp_d.size() - 1;
    n_cmp++;
    if (obs_o[4] !== 1'b0 || obs_o[5] !== 1'b1 || obs_o[last_i] !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow ovfl: got %b,%b,%b at cycles 4,5,end, want 0,1,1",
               obs_o[4], obs_o[5], obs_o[last_i]);
    end
    n_cmp++;
    if (obs_c[last_i] !== want_cnt || obs_c[last_i] >= 12'd12) begin
      n_fail++;
      $display("FAIL overflow wrd_cnt: got %0d, want %0d", obs_c[last_i], want_cnt);
    end
  endtask

  task automatic test_trunc();
    logic [15:0] ca, cb;
    int          eof1_i, last_i;
    sel = 2;
    do_reset();
    for (int i = 1; i <= 10; i++) stim(1'b1, 16'h0B00 + 16'(i), (i == 10), 1'b0);
    stim(1'b1, 16'hC001, 1'b0, 1'b0);
    stim(1'b1, 16'hC002, 1'b1, 1'b0);
    ca = 16'hFFFF;
    for (int i = 1; i <= 8; i++) ca = crc_ref(ca, 16'h0B00 + 16'(i));
    cb = crc_ref(crc_ref(16'hFFFF, 16'hC001), 16'hC002);
    e_idle(); e_sof();
    for (int i = 1; i <= 8; i++) e_word(16'h0B00 + 16'(i));
`ifdef CHANLINK_FRAME_CRC_EN
    e_word(ca);
    eof1_i = 11;
`else
    eof1_i = 10;
`endif
    e_eof(); e_idle(); e_sof(); e_word(16'hC001); e_word(16'hC002);
`ifdef CHANLINK_FRAME_CRC_EN
    e_word(cb);
`endif
    e_eof(); e_idle();
    run_cycles(exp_d.size());
    for (int i = 0; i < exp_d.size(); i++) begin
      n_cmp++;
      if (obs_d[i] !== exp_d[i] || obs_k[i] !== exp_k[i] || obs_f[i] !== exp_f[i]) begin
        n_fail++;
        $display("FAIL trunc cycle %0d: got txd=%h txk=%b frm=%b, want txd=%h txk=%b frm=%b",
                 i, obs_d[i], obs_k[i], obs_f[i], exp_d[i], exp_k[i], exp_f[i]);
      end
    end
    last_i = exp_d.size() - 1;
    n_cmp++;
    if (obs_t[8] !== 1'b0 || obs_t[9] !== 1'b1 || obs_t[last_i] !== 1'b1) begin
      n_fail++;
      $display("FAIL trunc flag: got %b,%b,%b at cycles 8,9,end, want 0,1,1",
               obs_t[8], obs_t[9], obs_t[last_i]);
    end
    n_cmp++;
    if (obs_c[eof1_i] !== 12'd8 || obs_c[last_i] !== 12'd2) begin
      n_fail++;
      $display("FAIL trunc wrd_cnt: got %0d then %0d, want 8 then 2", obs_c[eof1_i], obs_c[last_i]);
    end
  endtask

  task automatic test_reset_midframe();
    sel = 0;
    do_reset();
    stim(1'b1, 16'h1111, 1'b0, 1'b0);
    stim(1'b1, 16'h2222, 1'b1, 1'b0);
    stim(1'b0, 16'h0000, 1'b0, 1'b0);
    stim(1'b0, 16'h0000, 1'b0, 1'b1);
    e_idle(); e_sof(); e_word(16'h1111);
    for (int i = 0; i < 5; i++) e_idle();
    run_cycles(exp_d.size());
    for (int i = 0; i < exp_d.size(); i++) begin
      n_cmp++;
      if (obs_d[i] !== exp_d[i] || obs_k[i] !== exp_k[i] || obs_f[i] !== exp_f[i]) begin
        n_fail++;
        $display("FAIL reset_midframe cycle %0d: got txd=%h txk=%b frm=%b, want txd=%h txk=%b frm=%b",
                 i, obs_d[i], obs_k[i], obs_f[i], exp_d[i], exp_k[i], exp_f[i]);
      end
    end
    n_cmp++;
    if (obs_c[exp_d.size() - 1] !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_midframe wrd_cnt: got %0d, want 0", obs_c[exp_d.size() - 1]);
    end
  endtask

  initial begin
    test_reset();
    test_four_words();
    test_single_zero();
    test_back_to_back();
    test_overflow();
    test_trunc();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
